reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: the ALU result path and the data-memory load-return path.
- Arbitrates round-robin with valid/ready handshakes and registers the winning write one cycle before it reaches the register file.
- Keeps a 16-entry pending-load scoreboard so decode can stall on read-after-write hazards against in-flight loads.
- Sits between execute/memory stages and reg_file's write_en/address/data_in inputs.

Parameters:
- W, 8, data path width.
- D, 4, register pointer width; scoreboard depth 2**D.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU has a write pending.
- alu_ready  output  1  ALU write accepted this cycle.
- alu_addr  input  D  ALU destination register.
- alu_data  input  W  ALU write data.
- ld_valid  input  1  load return has a write pending.
- ld_ready  output  1  load write accepted this cycle.
- ld_addr  input  D  load destination register.
- ld_data  input  W  load write data.
- issue_en  input  1  a load is issued; marks issue_addr pending.
- issue_addr  input  D  destination of the issued load.
- query_addr  input  D  register decode wants to read.
- query_busy  output  1  combinational: scoreboard bit for query_addr.
- rf_we  output  1  registered write enable to the register file.
- rf_waddr  output  D  registered write address.
- rf_wdata  output  W  registered write data.
- sb_err  output  1  sticky: a load was issued to an already-pending register.

Behaviour:
- Reset (synchronous, active-high):
  - rf_we=0, rf_waddr=0, rf_wdata=0, sb_err=0.
  - All scoreboard bits 0.
  - Round-robin pointer last_grant=LD, so ALU has priority on the first contention.
  - Reset overrides every simultaneous event in that cycle.
- Arbitration is combinational within the cycle:
  - Only one valid: that source is granted.
  - Both valid: grant the source not equal to last_grant.
  - ready is asserted only for the granted source, same cycle. A handshake completes when valid && ready.
  - last_grant updates only on a granted cycle; it is unchanged on idle cycles.
- Output register:
  - On a grant, the next posedge sets rf_we=1 and loads rf_waddr/rf_wdata from the winner.
  - With no grant, rf_we=0 and rf_waddr/rf_wdata hold their values.
  - Latency is exactly 1 cycle, from handshake to rf_we.
  - The arbiter never back-pressures a lone requester; throughput is 1 write per cycle.
- A requester that loses must keep valid, addr and data stable until ready. With both requesters continuously valid the grants strictly alternate, giving a maximum wait of 1 cycle.
- Scoreboard:
  - issue_en sets busy[issue_addr].
  - A completed ld handshake clears busy[ld_addr].
  - Set and clear of the same address in one cycle: set wins, bit stays 1.
  - Set and clear of different addresses both take effect.
  - issue_en to an address whose bit is already 1 sets sb_err (sticky until reset); the bit stays 1.
  - ALU writes do not touch the scoreboard.
- query_busy reflects the registered scoreboard. It does not see an issue or clear made in the same cycle.
- Address 0 (the accumulator) is scoreboarded like any other register.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- Defined: adds outputs fwd_hit (1) and fwd_data (W), both combinational.
  - fwd_hit=1 when rf_we && rf_waddr==query_addr; fwd_data=rf_wdata.
  - This lets decode forward the write that is landing this cycle.
- Undefined: these ports are absent; decode must wait one extra cycle for the register file to update.

Decomposition:
- Add to package definitions:
  - typedef enum logic {REQ_ALU=1'b0, REQ_LD=1'b1} wb_src_t.
  - Constant kWbLatency=1.
- Sub-module rr_arb2: 2-requester round-robin arbiter with inputs req[1:0], CLK, reset and outputs gnt[1:0], last_grant. It holds the pointer state.
- reg_wb_arbiter instantiates rr_arb2 and contains the output register and the scoreboard.

Test Plan:
- Reset, then alu_valid=1, alu_addr=3, alu_data=8'h5A → alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=8'h5A; the following cycle rf_we=0.
- Both valid held for 4 cycles (ALU addr 1, LD addr 2) → grant order ALU, LD, ALU, LD; rf_waddr sequence 1,2,1,2 one cycle later.
- issue_en with issue_addr=7; query_addr=7 → query_busy=0 that cycle, then 1. An ld handshake to 7 then gives query_busy=0 the cycle after.
- issue_en with issue_addr=5 in the same cycle as an ld handshake to 5 (bit 5 was 1) → bit 5 remains 1 and sb_err=1.
- Assert reset mid-stream while both are valid and the scoreboard has bits 2 and 9 set → next cycle rf_we=0, all busy=0, sb_err=0; the first contention afterwards grants ALU.
- REG_WB_BYPASS_EN defined: ALU write to 4 with data 8'hC3, query_addr=4 → in the rf_we cycle fwd_hit=1 and fwd_data=8'hC3; with query_addr=6, fwd_hit=0.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package reg_wb_arbiter_pkg;

  typedef enum logic {REQ_ALU = 1'b0, REQ_LD = 1'b1} wb_src_t;

  localparam int kWbLatency = 1;

endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: req[0]=ALU, req[1]=LD; grant is combinational.
// The pointer moves only on a granted cycle; reset points at LD so ALU wins the first tie.
module rr_arb2
  import reg_wb_arbiter_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output wb_src_t    last_grant
);

  always_comb begin
    gnt = req;
    if (&req) gnt = (last_grant == REQ_LD) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge CLK) begin
    if (reset)
      last_grant <= REQ_LD;
    else if (|req)
      last_grant <= gnt[1] ? REQ_LD : REQ_ALU;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write port arbiter (ALU vs load return) with a pending-load scoreboard.
// Optional REG_WB_BYPASS_EN adds fwd_hit/fwd_data forwarding of the write landing this cycle.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic [D-1:0] alu_addr,
  input  logic [W-1:0] alu_data,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [D-1:0] ld_addr,
  input  logic [W-1:0] ld_data,
  input  logic         issue_en,
  input  logic [D-1:0] issue_addr,
  input  logic [D-1:0] query_addr,
  output logic         query_busy,
  output logic         rf_we,
  output logic [D-1:0] rf_waddr,
  output logic [W-1:0] rf_wdata,
  output logic         sb_err
`ifdef REG_WB_BYPASS_EN
  ,
  output logic         fwd_hit,
  output logic [W-1:0] fwd_data
`endif
);

  logic [1:0]      gnt;
  wb_src_t         last_grant;
  logic [2**D-1:0] busy;
  logic [2**D-1:0] busy_nxt;

  rr_arb2 u_arb (
    .CLK        (CLK),
    .reset      (reset),
    .req        ({ld_valid, alu_valid}),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  assign alu_ready  = gnt[0];
  assign ld_ready   = gnt[1];
  assign query_busy = busy[query_addr];

  // Under contention the winner must always be the source that did not win last.
  a_rr_alternate: assert property (@(posedge CLK) disable iff (reset)
    (alu_valid && ld_valid) |-> (gnt[1] == (last_grant == REQ_ALU)));

  always_ff @(posedge CLK) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (|gnt) begin
      rf_we    <= 1'b1;
      rf_waddr <= gnt[1] ? ld_addr : alu_addr;
      rf_wdata <= gnt[1] ? ld_data : alu_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Clear first, then set, so an issue to the register being returned keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (ld_valid && ld_ready) busy_nxt[ld_addr] = 1'b0;
    if (issue_en)             busy_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (issue_en && busy[issue_addr]) sb_err <= 1'b1;
    end
  end

`ifdef REG_WB_BYPASS_EN
  assign fwd_hit  = rf_we && (rf_waddr == query_addr);
  assign fwd_data = rf_wdata;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus a per-cycle reference model.
module tb_reg_wb_arbiter;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         reset;
  logic         alu_valid, alu_ready, ld_valid, ld_ready;
  logic [D-1:0] alu_addr, ld_addr, issue_addr, query_addr, rf_waddr;
  logic [W-1:0] alu_data, ld_data, rf_wdata;
  logic         issue_en, query_busy, rf_we, sb_err;
`ifdef REG_WB_BYPASS_EN
  logic         fwd_hit;
  logic [W-1:0] fwd_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  reg_wb_arbiter #(.W(W), .D(D)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .query_addr (query_addr),
    .query_busy (query_busy),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .sb_err     (sb_err)
`ifdef REG_WB_BYPASS_EN
    ,
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who won last, which registers have loads in flight,
  // and what the register file is being told to write this cycle.
  bit          m_ld_won_last;
  bit [15:0]   m_busy;
  bit          m_err;
  bit          m_we;
  bit [D-1:0]  m_waddr;
  bit [W-1:0]  m_wdata;

  function automatic bit win_alu();
    return alu_valid && (!ld_valid || m_ld_won_last);
  endfunction

  function automatic bit win_ld();
    return ld_valid && (!alu_valid || !m_ld_won_last);
  endfunction

  always @(posedge CLK) begin
    bit ga, gl;
    if (reset) begin
      m_ld_won_last = 1'b1;
      m_busy = '0;
      m_err = 1'b0;
      m_we = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      ga = win_alu();
      gl = win_ld();
      if (issue_en && m_busy[issue_addr]) m_err = 1'b1;
      if (gl) m_busy[ld_addr] = 1'b0;
      if (issue_en) m_busy[issue_addr] = 1'b1;
      m_we = ga || gl;
      if (ga) begin m_waddr = alu_addr; m_wdata = alu_data; end
      if (gl) begin m_waddr = ld_addr;  m_wdata = ld_data;  end
      if (ga || gl) m_ld_won_last = gl;
    end
  end

  always @(negedge CLK) begin
    if (chk_en && !reset) begin
      chk("m_alu_ready", alu_ready, win_alu());
      chk("m_ld_ready", ld_ready, win_ld());
      chk("m_query_busy", query_busy, m_busy[query_addr]);
      chk("m_rf_we", rf_we, m_we);
      chk("m_rf_waddr", rf_waddr, m_waddr);
      chk("m_rf_wdata", rf_wdata, m_wdata);
      chk("m_sb_err", sb_err, m_err);
`ifdef REG_WB_BYPASS_EN
      chk("m_fwd_hit", fwd_hit, m_we && (m_waddr == query_addr));
      chk("m_fwd_data", fwd_data, m_wdata);
`endif
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit a_pend, l_pend;
    reset = 1'b1;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0;  ld_addr = 0;  ld_data = 0;
    issue_en = 0;  issue_addr = 0; query_addr = 0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_sb_err", sb_err, 0);
    chk("rst_query_busy", query_busy, 0);

    // Lone ALU write
    alu_valid = 1; alu_addr = 3; alu_data = 8'h5A;
    #1;
    chk("alu_ready_lone", alu_ready, 1);
    chk("ld_ready_lone", ld_ready, 0);
    tick();
    alu_valid = 0;
    #1;
    chk("alu_wr_we", rf_we, 1);
    chk("alu_wr_addr", rf_waddr, 3);
    chk("alu_wr_data", rf_wdata, 8'h5A);
    tick();
    #1;
    chk("alu_wr_we_drop", rf_we, 0);
    chk("alu_wr_addr_hold", rf_waddr, 3);

    // Lone LD write so ALU wins the next tie
    ld_valid = 1; ld_addr = 15; ld_data = 8'h77;
    #1;
    chk("ld_ready_lone", ld_ready, 1);
    tick();
    ld_valid = 0;
    #1;
    chk("ld_wr_addr", rf_waddr, 15);
    chk("ld_wr_data", rf_wdata, 8'h77);

    // Continuous contention alternates ALU, LD, ALU, LD
    alu_valid = 1; alu_addr = 1; alu_data = 8'h11;
    ld_valid = 1;  ld_addr = 2;  ld_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_ld_ready", ld_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      #1;
      chk("rr_waddr", rf_waddr, (i % 2 == 0) ? 1 : 2);
    end
    alu_valid = 0; ld_valid = 0;
    tick();

    // Scoreboard set / clear on address 7
    issue_en = 1; issue_addr = 7; query_addr = 7;
    #1;
    chk("sb7_same_cycle", query_busy, 0);
    tick();
    issue_en = 0;
    #1;
    chk("sb7_set", query_busy, 1);
    ld_valid = 1; ld_addr = 7; ld_data = 8'h99;
    #1;
    chk("sb7_ld_ready", ld_ready, 1);
    chk("sb7_still_busy", query_busy, 1);
    tick();
    ld_valid = 0;
    #1;
    chk("sb7_cleared", query_busy, 0);

    // Set wins over clear on address 5, and re-issue flags an error
    issue_en = 1; issue_addr = 5;
    tick();
    ld_valid = 1; ld_addr = 5; ld_data = 8'h55;
    tick();
    issue_en = 0; ld_valid = 0; query_addr = 5;
    #1;
    chk("sb5_set_wins", query_busy, 1);
    chk("sb5_err", sb_err, 1);

    // Reset mid-stream with bits 2 and 9 set and both requesters valid
    issue_en = 1; issue_addr = 2;
    tick();
    issue_addr = 9;
    tick();
    issue_en = 0; query_addr = 9;
    #1;
    chk("pre_rst_busy9", query_busy, 1);
    alu_valid = 1; alu_addr = 6; alu_data = 8'hA6;
    ld_valid = 1;  ld_addr = 8;  ld_data = 8'hB8;
    reset = 1;
    tick();
    reset = 0; alu_valid = 0; ld_valid = 0;
    #1;
    chk("mid_rst_rf_we", rf_we, 0);
    chk("mid_rst_sb_err", sb_err, 0);
    for (int a = 0; a < 16; a++) begin
      query_addr = a[D-1:0];
      #1;
      chk("mid_rst_busy", query_busy, 0);
      tick();
    end
    alu_valid = 1; ld_valid = 1;
    #1;
    chk("post_rst_alu_first", alu_ready, 1);
    chk("post_rst_ld_waits", ld_ready, 0);
    tick();
    alu_valid = 0; ld_valid = 0;
    tick();

    // Mixed traffic; a requester that has not been accepted holds its request
    a_pend = 0; l_pend = 0;
    for (int i = 0; i < 300; i++) begin
      if (!a_pend) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr = D'($urandom);
        alu_data = W'($urandom);
      end
      if (!l_pend) begin
        ld_valid = ($urandom_range(0, 2) != 0);
        ld_addr = D'($urandom);
        ld_data = W'($urandom);
      end
      issue_en = ($urandom_range(0, 5) == 0);
      issue_addr = D'($urandom);
      query_addr = D'($urandom);
      #2;
      a_pend = alu_valid && !alu_ready;
      l_pend = ld_valid && !ld_ready;
      tick();
    end
    alu_valid = 0; ld_valid = 0; issue_en = 0;
    tick();

`ifdef REG_WB_BYPASS_EN
    alu_valid = 1; alu_addr = 4; alu_data = 8'hC3; query_addr = 4;
    tick();
    alu_valid = 0;
    #1;
    chk("fwd_hit_4", fwd_hit, 1);
    chk("fwd_data_4", fwd_data, 8'hC3);
    query_addr = 6;
    #1;
    chk("fwd_miss_6", fwd_hit, 0);
    tick();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
